// File: rtl/alu_issue_ctrl_if.sv
// Purpose : bundles the instruction, ALU, writeback and branch signals of the
//           execute-stage issue controller.
// Modports: slave  - the controller (accepts instructions, drives ALU/wb/br)
//           master - the surrounding pipeline/ALU environment
// Signals : instr_* (decoded instruction, valid/ready), alu_a/alu_b/
//           alu_operation/alu_out, wb_* (writeback valid/ready), br_valid/
//           br_taken, illegal_op.
interface alu_issue_ctrl_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_opcode;
  logic [DW-1:0] instr_rs_val;
  logic [DW-1:0] instr_rt_val;
  logic [15:0]   instr_imm;
  logic [RW-1:0] instr_rd;

  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [5:0]    alu_operation;
  logic [DW-1:0] alu_out;

  logic          wb_valid;
  logic          wb_ready;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;

  logic          br_valid;
  logic          br_taken;
  logic          illegal_op;

  modport slave (
    input  instr_valid, instr_opcode, instr_rs_val, instr_rt_val, instr_imm, instr_rd,
    output instr_ready,
    output alu_a, alu_b, alu_operation,
    input  alu_out,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    output br_valid, br_taken, illegal_op
  );

  modport master (
    output instr_valid, instr_opcode, instr_rs_val, instr_rt_val, instr_imm, instr_rd,
    input  instr_ready,
    input  alu_a, alu_b, alu_operation,
    output alu_out,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    input  br_valid, br_taken, illegal_op
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Purpose : execute-stage issue controller. Accepts one decoded instruction,
//           registers ALU operands and the 6-bit operation code, waits
//           ALU_LATENCY cycles, samples alu_out, then either offers a
//           writeback or resolves a branch. One instruction in flight.
// Ports   : clk    - clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - alu_issue_ctrl_if.slave (instruction, ALU, wb, branch)
//
// state | meaning
// IDLE  | instr_ready high, waiting for an instruction
// EXEC  | operands held on the ALU, latency counter running
// WB    | wb_valid offered until wb_ready
// BR    | one-cycle br_valid pulse with br_taken
// ILL   | one-cycle illegal_op pulse, nothing else touched
module alu_issue_ctrl #(
  parameter int DW          = 32,
  parameter int RW          = 5,
  parameter int ALU_LATENCY = 1
) (
  input logic             clk,
  input logic             rst_n,
  alu_issue_ctrl_if.slave bus
);

  localparam int CW = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;
  localparam logic [3:0] OP_BLTZ = 4'd11;
  localparam logic [3:0] OP_LUI  = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_WB,
    S_BR,
    S_ILL
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    opc_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] alu_a_q;
  logic [DW-1:0] alu_b_q;
  logic [5:0]    alu_op_q;
  logic          ready_q;
  logic          wb_valid_q;
  logic [RW-1:0] wb_rd_q;
  logic [DW-1:0] wb_data_q;
  logic          br_valid_q;
  logic          br_taken_q;
  logic          ill_q;

  logic [DW-1:0] alu_a_d;
  logic [DW-1:0] alu_b_d;
  logic [5:0]    alu_op_d;
  logic          ill_d;
  logic          is_branch;
  logic          br_res;

  // Operand/operation decode for the instruction currently offered.
  always_comb begin
    alu_a_d  = bus.instr_rs_val;
    alu_b_d  = bus.instr_rt_val;
    alu_op_d = 6'b000000;
    ill_d    = 1'b0;
    unique case (bus.instr_opcode)
      OP_ADD:  alu_op_d = 6'b000000;
      OP_SUB:  alu_op_d = 6'b000010;
      OP_ADDI: begin
        alu_b_d  = DW'($signed(bus.instr_imm));
        alu_op_d = 6'b000000;
      end
      OP_SLT:  alu_op_d = 6'b000100;
      OP_SLTU: alu_op_d = 6'b000101;
      OP_AND:  alu_op_d = 6'b001000;
      OP_OR:   alu_op_d = 6'b001100;
      OP_XOR:  alu_op_d = 6'b010000;
      OP_NOR:  alu_op_d = 6'b010100;
      OP_BEQ:  alu_op_d = 6'b000010;
      OP_BNE:  alu_op_d = 6'b000010;
      OP_BLTZ: begin
        alu_b_d  = '0;
        alu_op_d = 6'b000000;
      end
      OP_LUI: begin
        alu_a_d  = '0;
        alu_b_d  = DW'({bus.instr_imm, 16'h0000});
        alu_op_d = 6'b000000;
      end
      default: ill_d = 1'b1;
    endcase
  end

  // Branch outcome from the sampled ALU result; BEQ/BNE use a - b.
  always_comb begin
    is_branch = 1'b0;
    br_res    = 1'b0;
    case (opc_q)
      OP_BEQ: begin
        is_branch = 1'b1;
        br_res    = (bus.alu_out == '0);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        br_res    = (bus.alu_out != '0);
      end
      OP_BLTZ: begin
        is_branch = 1'b1;
        br_res    = bus.alu_out[DW-1];
      end
      default: begin
        is_branch = 1'b0;
        br_res    = 1'b0;
      end
    endcase
  end

  // Single FSM with registered outputs. instr_ready is registered too, so it
  // rises on the first edge after reset release and on every return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      opc_q      <= '0;
      rd_q       <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      ready_q    <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
      ill_q      <= 1'b0;
    end else begin
      br_valid_q <= 1'b0;
      ill_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && bus.instr_valid) begin
            ready_q <= 1'b0;
            opc_q   <= bus.instr_opcode;
            rd_q    <= bus.instr_rd;
            if (ill_d) begin
              // ALU operands deliberately left untouched for illegal opcodes.
              ill_q   <= 1'b1;
              state_q <= S_ILL;
            end else begin
              alu_a_q  <= alu_a_d;
              alu_b_q  <= alu_b_d;
              alu_op_q <= alu_op_d;
              cnt_q    <= CW'(ALU_LATENCY);
              state_q  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == CW'(1)) begin
            if (is_branch) begin
              br_valid_q <= 1'b1;
              br_taken_q <= br_res;
              state_q    <= S_BR;
            end else if (rd_q == '0) begin
              // Writes to r0 are discarded; no writeback handshake.
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_data_q  <= bus.alu_out;
              state_q    <= S_WB;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_WB: begin
          if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            ready_q    <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        S_BR: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_ILL: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready   = ready_q;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_operation = alu_op_q;
  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.br_valid      = br_valid_q;
  assign bus.br_taken      = br_taken_q;
  assign bus.illegal_op    = ill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_issue_ctrl_if #(.DW(32), .RW(5)) b1 ();
  alu_issue_ctrl_if #(.DW(32), .RW(5)) b3 ();

  alu_issue_ctrl #(.DW(32), .RW(5), .ALU_LATENCY(1)) u_l1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  alu_issue_ctrl #(.DW(32), .RW(5), .ALU_LATENCY(3)) u_l3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: [5:2] func, [1] invert b + carry-in, [0] unsigned compare.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] op);
    logic [31:0] bb;
    bb = op[1] ? ~b : b;
    case (op[5:2])
      4'd0:    return a + bb + {31'b0, op[1]};
      4'd1:    return op[0] ? {31'b0, (a < b)} : {31'b0, ($signed(a) < $signed(b))};
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~(a | b);
      default: return 32'h0;
    endcase
  endfunction

  assign b1.alu_out = alu_f(b1.alu_a, b1.alu_b, b1.alu_operation);
  assign b3.alu_out = alu_f(b3.alu_a, b3.alu_b, b3.alu_operation);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [15:0] imm, input logic [4:0] rd);
    b1.instr_valid  = 1'b1;
    b1.instr_opcode = op;
    b1.instr_rs_val = rs;
    b1.instr_rt_val = rt;
    b1.instr_imm    = imm;
    b1.instr_rd     = rd;
  endtask

  // Full writeback transaction on the latency-1 instance (wb_ready held high).
  task automatic run_wb(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] imm, input logic [4:0] rd,
                        input logic [5:0] exp_op, input logic [31:0] exp_data);
    chk({tag, "_rdy"}, b1.instr_ready, 1'b1);
    drive1(op, rs, rt, imm, rd);
    step();
    b1.instr_valid = 1'b0;
    chk({tag, "_op"}, b1.alu_operation, exp_op);
    chk({tag, "_busy"}, b1.instr_ready, 1'b0);
    step();
    chk({tag, "_wbv"}, b1.wb_valid, 1'b1);
    chk({tag, "_data"}, b1.wb_data, exp_data);
    chk({tag, "_rd"}, b1.wb_rd, rd);
    step();
    chk({tag, "_wbdone"}, b1.wb_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive1(4'd0, 32'h0, 32'h0, 16'h0, 5'd0);
    b1.instr_valid  = 1'b0;
    b1.wb_ready     = 1'b1;   // early/high wb_ready must be ignored outside WB
    b3.instr_valid  = 1'b0;
    b3.instr_opcode = 4'd0;
    b3.instr_rs_val = 32'h0;
    b3.instr_rt_val = 32'h0;
    b3.instr_imm    = 16'h0;
    b3.instr_rd     = 5'd0;
    b3.wb_ready     = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_rdy", b1.instr_ready, 1'b0);
    chk("rst_wbv", b1.wb_valid, 1'b0);
    chk("rst_a", b1.alu_a, 32'h0);
    chk("rst_op", b1.alu_operation, 6'h0);
    rst_n = 1'b1;
    step();
    chk("idle_rdy", b1.instr_ready, 1'b1);
    chk("idle_wbv_early_ready", b1.wb_valid, 1'b0);

    // 1: ADD wraps to 0, wb_valid two cycles after accept
    run_wb("add", 4'd0, 32'hFFFF_FFFF, 32'h1, 16'h0, 5'd3, 6'b000000, 32'h0);
    run_wb("sub", 4'd1, 32'd10, 32'd3, 16'h0, 5'd4, 6'b000010, 32'd7);
    run_wb("slt", 4'd3, 32'hFFFF_FFFF, 32'h1, 16'h0, 5'd5, 6'b000100, 32'd1);
    run_wb("sltu", 4'd4, 32'hFFFF_FFFF, 32'h1, 16'h0, 5'd6, 6'b000101, 32'd0);
    run_wb("and", 4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 16'h0, 5'd7, 6'b001000, 32'h00F0_1234);
    run_wb("or", 4'd6, 32'hA000_0000, 32'h0000_0005, 16'h0, 5'd8, 6'b001100, 32'hA000_0005);
    run_wb("xor", 4'd7, 32'hFFFF_0000, 32'h0F0F_0F0F, 16'h0, 5'd9, 6'b010000, 32'hF0F0_0F0F);
    run_wb("nor", 4'd8, 32'h0, 32'hFFFF_0000, 16'h0, 5'd10, 6'b010100, 32'h0000_FFFF);
    run_wb("addi", 4'd2, 32'd5, 32'h0, 16'hFFFE, 5'd11, 6'b000000, 32'd3);
    run_wb("lui", 4'd12, 32'h1234_5678, 32'h0, 16'hABCD, 5'd12, 6'b000000, 32'hABCD_0000);
    chk("lui_a", b1.alu_a, 32'h0);

    // 2: BEQ taken, BNE not taken, BLTZ taken
    drive1(4'd9, 32'h1234, 32'h1234, 16'h0, 5'd7);
    step();
    b1.instr_valid = 1'b0;
    chk("beq_op", b1.alu_operation, 6'b000010);
    step();
    chk("beq_brv", b1.br_valid, 1'b1);
    chk("beq_taken", b1.br_taken, 1'b1);
    chk("beq_nowb", b1.wb_valid, 1'b0);
    step();
    chk("beq_pulse", b1.br_valid, 1'b0);
    chk("beq_hold", b1.br_taken, 1'b1);
    chk("beq_rdy", b1.instr_ready, 1'b1);
    drive1(4'd10, 32'h1234, 32'h1234, 16'h0, 5'd7);
    step();
    b1.instr_valid = 1'b0;
    step();
    chk("bne_brv", b1.br_valid, 1'b1);
    chk("bne_taken", b1.br_taken, 1'b0);
    step();
    drive1(4'd11, 32'h8000_0000, 32'h5, 16'h0, 5'd1);
    step();
    b1.instr_valid = 1'b0;
    chk("bltz_b", b1.alu_b, 32'h0);
    step();
    chk("bltz_taken", b1.br_taken, 1'b1);
    chk("bltz_nowb", b1.wb_valid, 1'b0);
    step();

    // 3: ADDI to r0 -> no writeback, ready back after 1+L cycles
    drive1(4'd2, 32'd5, 32'h0, 16'hFFFE, 5'd0);
    step();
    b1.instr_valid = 1'b0;
    chk("r0_b", b1.alu_b, 32'hFFFF_FFFE);
    chk("r0_busy", b1.instr_ready, 1'b0);
    step();
    chk("r0_rdy", b1.instr_ready, 1'b1);
    chk("r0_nowb", b1.wb_valid, 1'b0);
    chk("r0_data_hold", b1.wb_data, 32'hABCD_0000);

    // 5: illegal opcode 14, ALU outputs unchanged, next accept 2 cycles later
    drive1(4'd14, 32'h1111_1111, 32'h2222_2222, 16'h3333, 5'd9);
    step();
    b1.instr_valid = 1'b0;
    chk("ill_pulse", b1.illegal_op, 1'b1);
    chk("ill_b_hold", b1.alu_b, 32'hFFFF_FFFE);
    chk("ill_a_hold", b1.alu_a, 32'd5);
    chk("ill_busy", b1.instr_ready, 1'b0);
    step();
    chk("ill_clear", b1.illegal_op, 1'b0);
    chk("ill_rdy", b1.instr_ready, 1'b1);
    chk("ill_nowb", b1.wb_valid, 1'b0);
    chk("ill_nobr", b1.br_valid, 1'b0);
    run_wb("post_ill", 4'd0, 32'd20, 32'd22, 16'h0, 5'd2, 6'b000000, 32'd42);

    // 4: SUB on latency-3 instance with wb_ready low for 10 cycles
    step();
    chk("l3_rdy", b3.instr_ready, 1'b1);
    b3.instr_valid  = 1'b1;
    b3.instr_opcode = 4'd1;
    b3.instr_rs_val = 32'd100;
    b3.instr_rt_val = 32'd58;
    b3.instr_rd     = 5'd5;
    step();
    b3.instr_valid = 1'b0;
    chk("l3_op", b3.alu_operation, 6'b000010);
    step();
    chk("l3_wait1", b3.wb_valid, 1'b0);
    step();
    chk("l3_wait2", b3.wb_valid, 1'b0);
    step();
    chk("l3_wbv", b3.wb_valid, 1'b1);
    chk("l3_data", b3.wb_data, 32'd42);
    chk("l3_rd", b3.wb_rd, 5'd5);
    // A new instruction offered during the stall must not be taken.
    b3.instr_valid  = 1'b1;
    b3.instr_opcode = 4'd0;
    b3.instr_rs_val = 32'd1;
    b3.instr_rt_val = 32'd1;
    b3.instr_rd     = 5'd6;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("l3_stall_v", b3.wb_valid, 1'b1);
      chk("l3_stall_d", b3.wb_data, 32'd42);
      chk("l3_stall_r", b3.instr_ready, 1'b0);
    end
    chk("l3_stall_op", b3.alu_operation, 6'b000010);
    b3.instr_valid = 1'b0;
    b3.wb_ready    = 1'b1;
    step();
    chk("l3_done", b3.wb_valid, 1'b0);
    chk("l3_rdy_back", b3.instr_ready, 1'b1);

    // 6: reset during EXEC drops the instruction
    drive1(4'd0, 32'd7, 32'd8, 16'h0, 5'd4);
    step();
    b1.instr_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a", b1.alu_a, 32'h0);
    chk("mid_rst_op", b1.alu_operation, 6'h0);
    chk("mid_rst_wbd", b1.wb_data, 32'h0);
    chk("mid_rst_brt", b1.br_taken, 1'b0);
    chk("mid_rst_rdy", b1.instr_ready, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_rdy", b1.instr_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_nowb", b1.wb_valid, 1'b0);
      chk("post_rst_nobr", b1.br_valid, 1'b0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
